pmem_arbiter: RTL and testbench

// - Arbitrates NUM_PORTS cache-line requesters (I-cache, D-cache, prefetch/victim buffers) onto one physical memory port.
// - Successor to the fixed two-way I/D arbiter: parametrised port count and widths, round-robin or fixed priority,

---
 rtl/pmem_arbiter_if.sv | 35 +++
 rtl/pmem_arbiter.sv | 120 ++++++++++++
 tb/tb_pmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - requester and physical memory signal bundle for pmem_arbiter
interface pmem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  localparam int ID_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [LINE_WIDTH-1:0]           req_rdata;
  logic [ID_W-1:0]                 grant_id;
  logic                            busy;
  logic                            pmem_read;
  logic                            pmem_write;
  logic [ADDR_WIDTH-1:0]           pmem_address;
  logic [LINE_WIDTH-1:0]           pmem_wdata;
  logic                            pmem_resp;
  logic [LINE_WIDTH-1:0]           pmem_rdata;

  // Arbiter side
  modport slave (
    input  req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
    output req_resp, req_rdata, grant_id, busy, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Requesters plus physical memory side
  modport master (
    output req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
    input  req_resp, req_rdata, grant_id, busy, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - N-port cache-line arbiter onto a single physical memory port
module pmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int RR_MODE    = 1
) (
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        last;
  logic [ID_W-1:0]        winner;
  logic [NUM_PORTS-1:0]   pending;
  logic                   any_pending;

  logic [NUM_PORTS-1:0]   resp_q;
  logic [LINE_WIDTH-1:0]  rdata_q;
  logic [ID_W-1:0]        grant_q;
  logic                   busy_q;
  logic                   rd_q;
  logic                   wr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  wdata_q;

  assign pending     = bus.req_read | bus.req_write;
  assign any_pending = |pending;

  // Pick the winner: rotating search starting after the last grant, or lowest index
  always_comb begin
    logic [ID_W:0] cand;
    logic          found;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        cand = {1'b0, last} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_PORTS)) begin
          cand = cand - (ID_W+1)'(NUM_PORTS);
        end
      end else begin
        cand = (ID_W+1)'(k - 1);
      end
      if (!found && pending[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  // Grant / wait-for-memory / respond sequencer with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= ID_W'(NUM_PORTS - 1);
      resp_q  <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      resp_q <= '0;
      case (state)
        IDLE: begin
          if (any_pending) begin
            addr_q  <= bus.req_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= bus.req_wdata[winner*LINE_WIDTH +: LINE_WIDTH];
            // a port raising both read and write is treated as a write
            wr_q    <= bus.req_write[winner];
            rd_q    <= ~bus.req_write[winner];
            grant_q <= winner;
            if (RR_MODE != 0) begin
              last <= winner;
            end
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.pmem_resp) begin
            rdata_q         <= bus.pmem_rdata;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            resp_q[grant_q] <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_resp     = resp_q;
  assign bus.req_rdata    = rdata_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = busy_q;
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter in 2-port RR, 2-port fixed and 4-port RR builds
module tb_pmem_arbiter;
  logic clk = 1'b0;
  logic rst;

  // clock generation
  always #5 clk = ~clk;

  // stimulus arrays, index 0 = 2-port RR, 1 = 2-port fixed, 2 = 4-port RR
  logic [3:0]   t_rd    [3];
  logic [3:0]   t_wr    [3];
  logic [15:0]  t_addr  [3][4];
  logic [127:0] t_wdata [3][4];
  logic         t_presp [3];
  logic [127:0] t_prdata[3];

  logic [3:0]   o_resp  [3];
  logic [127:0] o_rdata [3];
  logic [1:0]   o_gid   [3];
  logic         o_busy  [3];
  logic         o_pr    [3];
  logic         o_pw    [3];
  logic [15:0]  o_paddr [3];
  logic [127:0] o_pwdata[3];

  pmem_arbiter_if #(.NUM_PORTS(2)) ia ();
  pmem_arbiter_if #(.NUM_PORTS(2)) ib ();
  pmem_arbiter_if #(.NUM_PORTS(4)) ic ();

  pmem_arbiter #(.NUM_PORTS(2), .RR_MODE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  pmem_arbiter #(.NUM_PORTS(2), .RR_MODE(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  pmem_arbiter #(.NUM_PORTS(4), .RR_MODE(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  assign ia.req_read    = t_rd[0][1:0];
  assign ia.req_write   = t_wr[0][1:0];
  assign ia.req_address = {t_addr[0][1], t_addr[0][0]};
  assign ia.req_wdata   = {t_wdata[0][1], t_wdata[0][0]};
  assign ia.pmem_resp   = t_presp[0];
  assign ia.pmem_rdata  = t_prdata[0];
  assign ib.req_read    = t_rd[1][1:0];
  assign ib.req_write   = t_wr[1][1:0];
  assign ib.req_address = {t_addr[1][1], t_addr[1][0]};
  assign ib.req_wdata   = {t_wdata[1][1], t_wdata[1][0]};
  assign ib.pmem_resp   = t_presp[1];
  assign ib.pmem_rdata  = t_prdata[1];
  assign ic.req_read    = t_rd[2];
  assign ic.req_write   = t_wr[2];
  assign ic.req_address = {t_addr[2][3], t_addr[2][2], t_addr[2][1], t_addr[2][0]};
  assign ic.req_wdata   = {t_wdata[2][3], t_wdata[2][2], t_wdata[2][1], t_wdata[2][0]};
  assign ic.pmem_resp   = t_presp[2];
  assign ic.pmem_rdata  = t_prdata[2];

  assign o_resp[0] = {2'b00, ia.req_resp};
  assign o_resp[1] = {2'b00, ib.req_resp};
  assign o_resp[2] = ic.req_resp;
  assign o_rdata[0] = ia.req_rdata;
  assign o_rdata[1] = ib.req_rdata;
  assign o_rdata[2] = ic.req_rdata;
  assign o_gid[0] = {1'b0, ia.grant_id};
  assign o_gid[1] = {1'b0, ib.grant_id};
  assign o_gid[2] = ic.grant_id;
  assign o_busy[0] = ia.busy;
  assign o_busy[1] = ib.busy;
  assign o_busy[2] = ic.busy;
  assign o_pr[0] = ia.pmem_read;
  assign o_pr[1] = ib.pmem_read;
  assign o_pr[2] = ic.pmem_read;
  assign o_pw[0] = ia.pmem_write;
  assign o_pw[1] = ib.pmem_write;
  assign o_pw[2] = ic.pmem_write;
  assign o_paddr[0] = ia.pmem_address;
  assign o_paddr[1] = ib.pmem_address;
  assign o_paddr[2] = ic.pmem_address;
  assign o_pwdata[0] = ia.pmem_wdata;
  assign o_pwdata[1] = ib.pmem_wdata;
  assign o_pwdata[2] = ic.pmem_wdata;

  int           checks = 0;
  int           errors = 0;
  int           cur = 0;
  int           glog[$];
  int           rem [3][4];
  int           mem_cnt [3];
  bit           mem_auto [3];
  int           mem_delay = 1;
  logic [127:0] mem_line = '0;

  typedef struct {
    int         d;
    logic [3:0] rd;
    logic [3:0] wr;
    int         gid;
    logic       prd;
    logic       pwr;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [15:0] addr_of(int d, int p);
    return 16'(32'h1000 + d * 32'h1000 + p * 32'h110);
  endfunction

  function automatic logic [127:0] wdata_of(int d, int p);
    return {8{16'(32'hB000 + d * 16 + p)}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // advance to the next falling edge and run the memory and requester models there
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rw_exclusive_d%0d", d), 128'(o_pr[d] & o_pw[d]), 128'(0));
      chk($sformatf("resp_onehot_d%0d", d), 128'($countones(o_resp[d]) > 1), 128'(0));
      if (mem_auto[d]) begin
        t_presp[d] = 1'b0;
        if (o_pr[d] | o_pw[d]) begin
          if (mem_cnt[d] >= mem_delay - 1) begin
            t_presp[d]  = 1'b1;
            t_prdata[d] = mem_line;
            mem_cnt[d]  = 0;
          end else begin
            mem_cnt[d]++;
          end
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (o_resp[d][p] && rem[d][p] > 0) begin
          chk($sformatf("gid_at_resp_d%0d", d), 128'(o_gid[d]), 128'(p));
          rem[d][p]--;
          if (d == cur) glog.push_back(p);
          if (rem[d][p] == 0) begin
            t_rd[d][p] = 1'b0;
            t_wr[d][p] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 3; d++) begin
      t_rd[d] = '0;
      t_wr[d] = '0;
      t_presp[d] = 1'b0;
      t_prdata[d] = '0;
      mem_cnt[d] = 0;
      mem_auto[d] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        t_addr[d][p]  = addr_of(d, p);
        t_wdata[d][p] = wdata_of(d, p);
        rem[d][p] = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_resp(int d, output int n);
    n = 0;
    while (o_resp[d] == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
  endtask

  // keep ports requesting until each has been served r[p] times and compare the service order
  task automatic run_cont(int d, logic [3:0] mask, int r0, int r1, int r2, int r3,
                          int e0, int e1, int e2, int e3, int e4, int n);
    int exp_seq[5];
    int cnt;
    exp_seq = '{e0, e1, e2, e3, e4};
    cur = d;
    glog.delete();
    rem[d][0] = r0; rem[d][1] = r1; rem[d][2] = r2; rem[d][3] = r3;
    t_rd[d] = mask;
    cnt = 0;
    while ((rem[d][0] + rem[d][1] + rem[d][2] + rem[d][3]) > 0 && cnt < 200) begin
      tick();
      cnt++;
    end
    tick();
    chk($sformatf("cont_len_d%0d", d), 128'(glog.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      if (i < glog.size()) chk($sformatf("cont_order_d%0d_%0d", d, i), 128'(glog[i]), 128'(exp_seq[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int g;

    vecs[0]  = '{2, 4'b0001, 4'b0000, 0, 1'b1, 1'b0};
    vecs[1]  = '{2, 4'b1111, 4'b0000, 1, 1'b1, 1'b0};
    vecs[2]  = '{2, 4'b0000, 4'b0100, 2, 1'b0, 1'b1};
    vecs[3]  = '{2, 4'b1011, 4'b0000, 3, 1'b1, 1'b0};
    vecs[4]  = '{2, 4'b0110, 4'b0000, 1, 1'b1, 1'b0};
    vecs[5]  = '{2, 4'b0001, 4'b0001, 0, 1'b0, 1'b1};
    vecs[6]  = '{2, 4'b1001, 4'b0000, 3, 1'b1, 1'b0};
    vecs[7]  = '{1, 4'b0011, 4'b0000, 0, 1'b1, 1'b0};
    vecs[8]  = '{1, 4'b0010, 4'b0000, 1, 1'b1, 1'b0};
    vecs[9]  = '{1, 4'b0011, 4'b0010, 0, 1'b1, 1'b0};
    vecs[10] = '{1, 4'b0000, 4'b0011, 0, 1'b0, 1'b1};
    vecs[11] = '{0, 4'b0011, 4'b0000, 0, 1'b1, 1'b0};
    vecs[12] = '{0, 4'b0011, 4'b0000, 1, 1'b1, 1'b0};
    vecs[13] = '{0, 4'b0010, 4'b0001, 0, 1'b0, 1'b1};

    rst = 1'b1;
    clear_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pmem_read_d%0d", k), 128'(o_pr[k]), 128'(0));
      chk($sformatf("rst_pmem_write_d%0d", k), 128'(o_pw[k]), 128'(0));
      chk($sformatf("rst_busy_d%0d", k), 128'(o_busy[k]), 128'(0));
      chk($sformatf("rst_grant_id_d%0d", k), 128'(o_gid[k]), 128'(0));
      chk($sformatf("rst_resp_d%0d", k), 128'(o_resp[k]), 128'(0));
      chk($sformatf("rst_addr_d%0d", k), 128'(o_paddr[k]), 128'(0));
      chk($sformatf("rst_wdata_d%0d", k), o_pwdata[k], 128'(0));
      chk($sformatf("rst_rdata_d%0d", k), o_rdata[k], 128'(0));
    end
    tick();
    rst = 1'b0;
    tick();

    // single-transaction vectors; expected winners follow the arbitration history above
    mem_delay = 1;
    for (int i = 0; i < 14; i++) begin
      d = vecs[i].d;
      g = vecs[i].gid;
      cur = d;
      mem_line = {8{16'(32'hC000 + i)}};
      t_rd[d] = vecs[i].rd;
      t_wr[d] = vecs[i].wr;
      tick();
      chk($sformatf("vec%0d_grant_id", i), 128'(o_gid[d]), 128'(g));
      chk($sformatf("vec%0d_pmem_read", i), 128'(o_pr[d]), 128'(vecs[i].prd));
      chk($sformatf("vec%0d_pmem_write", i), 128'(o_pw[d]), 128'(vecs[i].pwr));
      chk($sformatf("vec%0d_addr", i), 128'(o_paddr[d]), 128'(addr_of(d, g)));
      chk($sformatf("vec%0d_wdata", i), o_pwdata[d], wdata_of(d, g));
      chk($sformatf("vec%0d_busy", i), 128'(o_busy[d]), 128'(1));
      wait_resp(d, n);
      chk($sformatf("vec%0d_resp", i), 128'(o_resp[d]), 128'(4'b0001 << g));
      chk($sformatf("vec%0d_rdata", i), o_rdata[d], mem_line);
      t_rd[d] = '0;
      t_wr[d] = '0;
      tick();
    end

    // port 0 read with a slow memory: strobe in t+1, response in t+6
    cur = 0;
    mem_delay = 5;
    mem_line = {16{8'hA5}};
    t_addr[0][0] = 16'h1230;
    t_rd[0][0] = 1'b1;
    chk("a_strobe_at_t", 128'(o_pr[0]), 128'(0));
    tick();
    chk("a_pmem_read_t1", 128'(o_pr[0]), 128'(1));
    chk("a_pmem_addr", 128'(o_paddr[0]), 128'(16'h1230));
    n = 1;
    while (o_resp[0] == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    chk("a_resp_latency", 128'(n), 128'(6));
    chk("a_resp_bit", 128'(o_resp[0]), 128'(4'b0001));
    chk("a_rdata", o_rdata[0], {16{8'hA5}});
    t_rd[0][0] = 1'b0;
    tick();
    chk("a_resp_one_cycle", 128'(o_resp[0]), 128'(0));
    chk("a_busy_back_idle", 128'(o_busy[0]), 128'(0));

    // port 1 write; requester inputs scrambled while BUSY must not reach pmem
    mem_delay = 4;
    t_addr[0][1] = 16'h00F0;
    t_wdata[0][1] = {4{32'hDEADBEEF}};
    t_wr[0][1] = 1'b1;
    tick();
    chk("b_pmem_write", 128'(o_pw[0]), 128'(1));
    chk("b_grant_id", 128'(o_gid[0]), 128'(1));
    t_addr[0][1] = 16'h5555;
    t_wdata[0][1] = {4{32'h01234567}};
    n = 0;
    while (o_resp[0] == 4'b0000 && n < 30) begin
      chk("b_addr_held", 128'(o_paddr[0]), 128'(16'h00F0));
      chk("b_wdata_held", o_pwdata[0], {4{32'hDEADBEEF}});
      tick();
      n++;
    end
    chk("b_resp_bit", 128'(o_resp[0]), 128'(4'b0010));
    t_wr[0][1] = 1'b0;
    t_addr[0][1] = addr_of(0, 1);
    t_wdata[0][1] = wdata_of(0, 1);
    tick();

    // reset in the middle of a transaction, then a stray late pmem_resp
    mem_auto[0] = 1'b0;
    t_presp[0] = 1'b0;
    t_rd[0][1] = 1'b1;
    tick();
    chk("c_pmem_read_before_rst", 128'(o_pr[0]), 128'(1));
    #2;
    rst = 1'b1;
    t_rd[0] = '0;
    #1;
    chk("c_rst_pmem_read", 128'(o_pr[0]), 128'(0));
    chk("c_rst_busy", 128'(o_busy[0]), 128'(0));
    chk("c_rst_grant_id", 128'(o_gid[0]), 128'(0));
    chk("c_rst_addr", 128'(o_paddr[0]), 128'(0));
    chk("c_rst_rdata", o_rdata[0], 128'(0));
    tick();
    rst = 1'b0;
    t_presp[0] = 1'b1;
    t_prdata[0] = {4{32'hBADBAD00}};
    tick();
    t_presp[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("c_no_resp_after_rst", 128'(o_resp[0]), 128'(0));
      chk("c_idle_after_rst", 128'(o_busy[0]), 128'(0));
      tick();
    end
    mem_auto[0] = 1'b1;
    mem_cnt[0] = 0;
    mem_delay = 1;
    t_rd[0] = 4'b0011;
    tick();
    chk("c_next_grant_port0", 128'(o_gid[0]), 128'(0));
    chk("c_next_pmem_read", 128'(o_pr[0]), 128'(1));
    wait_resp(0, n);
    chk("c_next_resp", 128'(o_resp[0]), 128'(4'b0001));
    t_rd[0] = '0;
    tick();

    // continuous requesters
    do_reset();
    mem_delay = 2;
    run_cont(0, 4'b0011, 2, 2, 0, 0, 0, 1, 0, 1, 0, 4);
    run_cont(1, 4'b0011, 2, 2, 0, 0, 0, 0, 1, 1, 0, 4);
    run_cont(2, 4'b1111, 2, 1, 1, 1, 0, 1, 2, 3, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
